// File: rtl/exc_sequencer.sv
// Exception/interrupt entry and ERET return sequencer around CP0: arbitrates commit-stage
// requests, strobes CP0, flushes/stalls the pipeline, then redirects the PC.
module exc_sequencer #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_F000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        irq_i,
  input  logic        exc_ov_i,
  input  logic        exc_ri_i,
  input  logic        exc_sys_i,
  input  logic        exc_bp_i,
  input  logic        eret_i,
  input  logic [31:0] cp0_epc_i,
  output logic        exception_o,
  output logic [4:0]  cause_type_o,
  output logic [31:0] epc_o,
  output logic        exl_clr_o,
  output logic        flush_o,
  output logic        stall_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TAKE,
    S_ERET,
    S_FLUSH,
    S_REDIRECT
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] target_q, target_d;
  logic        exc_req;

  assign exc_req = irq_i | exc_ov_i | exc_ri_i | exc_sys_i | exc_bp_i;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    code_d   = code_q;
    epc_d    = epc_q;
    target_d = target_q;
    unique case (state_q)
      S_IDLE: begin
        if (mem_valid_i && exc_req) begin
          // Fixed priority; losers in the same cycle are dropped.
          if (irq_i)          code_d = 5'd0;
          else if (exc_ov_i)  code_d = 5'd12;
          else if (exc_ri_i)  code_d = 5'd10;
          else if (exc_sys_i) code_d = 5'd8;
          else                code_d = 5'd9;
          epc_d    = mem_pc_i;
          target_d = HANDLER_ADDR;
          state_d  = S_TAKE;
        end else if (mem_valid_i && eret_i) begin
          target_d = cp0_epc_i;
          state_d  = S_ERET;
        end
      end
      S_TAKE, S_ERET: begin
        cnt_d   = 4'(FLUSH_CYCLES - 1);
        state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (cnt_q == 4'd0) state_d = S_REDIRECT;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_REDIRECT: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      code_q   <= '0;
      epc_q    <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      code_q   <= code_d;
      epc_q    <= epc_d;
      target_q <= target_d;
    end
  end

  // Outputs decode purely from registered state, so async reset clears them at once.
  always_comb begin
    exception_o   = 1'b0;
    cause_type_o  = '0;
    epc_o         = '0;
    exl_clr_o     = 1'b0;
    flush_o       = 1'b0;
    stall_o       = 1'b0;
    redirect_o    = 1'b0;
    redirect_pc_o = '0;
    unique case (state_q)
      S_TAKE: begin
        exception_o  = 1'b1;
        cause_type_o = code_q;
        epc_o        = epc_q;
        flush_o      = 1'b1;
        stall_o      = 1'b1;
      end
      S_ERET: begin
        exl_clr_o = 1'b1;
        flush_o   = 1'b1;
        stall_o   = 1'b1;
      end
      S_FLUSH: begin
        flush_o = 1'b1;
        stall_o = 1'b1;
      end
      S_REDIRECT: begin
        redirect_o    = 1'b1;
        redirect_pc_o = target_q;
        stall_o       = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_exc_sequencer.sv
// Scoreboard bench for exc_sequencer: stimulus pushes expected strobe events, monitors pop
// and compare them whenever a DUT raises exception_o, exl_clr_o or redirect_o.
module tb_exc_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        mv, irq, ov, ri, sys, bp, er;
  logic [31:0] pc, cp0_epc;
  logic        exc0, exl0, flush0, stall0, redir0;
  logic [4:0]  cause0;
  logic [31:0] epc0, rpc0;

  logic        mv1, sys1;
  logic        exc1, exl1, flush1, stall1, redir1;
  logic [4:0]  cause1;
  logic [31:0] epc1, rpc1;

  exc_sequencer #(.HANDLER_ADDR(32'h0000_F000), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .mem_valid_i(mv), .mem_pc_i(pc), .irq_i(irq),
    .exc_ov_i(ov), .exc_ri_i(ri), .exc_sys_i(sys), .exc_bp_i(bp), .eret_i(er),
    .cp0_epc_i(cp0_epc), .exception_o(exc0), .cause_type_o(cause0), .epc_o(epc0),
    .exl_clr_o(exl0), .flush_o(flush0), .stall_o(stall0), .redirect_o(redir0),
    .redirect_pc_o(rpc0)
  );

  exc_sequencer #(.HANDLER_ADDR(32'h0000_F000), .FLUSH_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .mem_valid_i(mv1), .mem_pc_i(pc), .irq_i(1'b0),
    .exc_ov_i(1'b0), .exc_ri_i(1'b0), .exc_sys_i(sys1), .exc_bp_i(1'b0), .eret_i(1'b0),
    .cp0_epc_i(32'h0), .exception_o(exc1), .cause_type_o(cause1), .epc_o(epc1),
    .exl_clr_o(exl1), .flush_o(flush1), .stall_o(stall1), .redirect_o(redir1),
    .redirect_pc_o(rpc1)
  );

  // kind: 0 = exception strobe, 1 = ERET strobe, 2 = redirect
  typedef struct {
    int          kind;
    logic [4:0]  code;
    logic [31:0] val;
    int          at;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;
  int   total = 0;
  int   bad = 0;
  int   ecnt = 0;

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int kind, input logic [4:0] code, input logic [31:0] val,
                              input int at);
    exp_t e;
    e.kind = kind;
    e.code = code;
    e.val  = val;
    e.at   = at;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && (exc0 || exl0 || redir0)) begin
      if (q0.size() == 0) begin
        cmp("unexpected_evt0", {29'b0, exc0, exl0, redir0}, 32'h0);
      end else begin
        e0 = q0.pop_front();
        cmp("kind0", exc0 ? 0 : (exl0 ? 1 : 2), e0.kind);
        cmp("cycle0", ecnt, e0.at);
        cmp("exc_exl_excl0", {31'b0, exc0 & exl0}, 32'h0);
        cmp("flush0", {31'b0, flush0}, (e0.kind != 2) ? 32'h1 : 32'h0);
        cmp("stall0", {31'b0, stall0}, 32'h1);
        if (e0.kind == 0) begin
          cmp("cause0", {27'b0, cause0}, {27'b0, e0.code});
          cmp("epc0", epc0, e0.val);
        end else begin
          cmp("cause_idle0", {27'b0, cause0}, 32'h0);
        end
        if (e0.kind == 2) cmp("redirect_pc0", rpc0, e0.val);
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && (exc1 || exl1 || redir1)) begin
      if (q1.size() == 0) begin
        cmp("unexpected_evt1", {29'b0, exc1, exl1, redir1}, 32'h0);
      end else begin
        e1 = q1.pop_front();
        cmp("kind1", exc1 ? 0 : (exl1 ? 1 : 2), e1.kind);
        cmp("cycle1", ecnt, e1.at);
        cmp("flush1", {31'b0, flush1}, (e1.kind != 2) ? 32'h1 : 32'h0);
        if (e1.kind == 0) cmp("cause1", {27'b0, cause1}, {27'b0, e1.code});
        if (e1.kind == 0) cmp("epc1", epc1, e1.val);
        if (e1.kind == 2) cmp("redirect_pc1", rpc1, e1.val);
      end
    end
  end

  task automatic issue0(input logic v, input logic i_irq, input logic i_ov, input logic i_ri,
                        input logic i_sys, input logic i_bp, input logic i_er,
                        input logic [31:0] i_pc, input logic [31:0] i_epc, output int k);
    @(posedge clk);
    #1;
    mv = v; irq = i_irq; ov = i_ov; ri = i_ri; sys = i_sys; bp = i_bp; er = i_er;
    pc = i_pc; cp0_epc = i_epc;
    k = ecnt + 1;
    @(posedge clk);
    #1;
    mv = 0; irq = 0; ov = 0; ri = 0; sys = 0; bp = 0; er = 0;
  endtask

  int k;

  initial begin
    rst = 1; mv = 0; irq = 0; ov = 0; ri = 0; sys = 0; bp = 0; er = 0;
    pc = '0; cp0_epc = '0; mv1 = 0; sys1 = 0;
    #12;
    cmp("rst_exception", {31'b0, exc0}, 32'h0);
    cmp("rst_flush", {31'b0, flush0}, 32'h0);
    cmp("rst_stall", {31'b0, stall0}, 32'h0);
    cmp("rst_redirect", {31'b0, redir0}, 32'h0);
    cmp("rst_rpc", rpc0, 32'h0);
    cmp("rst_exl", {31'b0, exl0}, 32'h0);
    @(posedge clk); #1 rst = 0;

    // Overflow
    issue0(1, 0, 1, 0, 0, 0, 0, 32'h100, 32'h0, k);
    q0.push_back(mk(0, 5'd12, 32'h100, k));
    q0.push_back(mk(2, 5'd0, 32'h0000_F000, k + 3));
    repeat (5) @(posedge clk);

    // irq beats syscall
    issue0(1, 1, 0, 0, 1, 0, 0, 32'h40, 32'h0, k);
    q0.push_back(mk(0, 5'd0, 32'h40, k));
    q0.push_back(mk(2, 5'd0, 32'h0000_F000, k + 3));
    repeat (5) @(posedge clk);

    // ERET alone
    issue0(1, 0, 0, 0, 0, 0, 1, 32'h44, 32'h200, k);
    q0.push_back(mk(1, 5'd0, 32'h0, k));
    q0.push_back(mk(2, 5'd0, 32'h200, k + 3));
    repeat (5) @(posedge clk);

    // syscall beats break; break beats ERET
    issue0(1, 0, 0, 0, 1, 1, 0, 32'h60, 32'h0, k);
    q0.push_back(mk(0, 5'd8, 32'h60, k));
    q0.push_back(mk(2, 5'd0, 32'h0000_F000, k + 3));
    repeat (5) @(posedge clk);
    issue0(1, 0, 0, 0, 0, 1, 1, 32'h64, 32'h300, k);
    q0.push_back(mk(0, 5'd9, 32'h64, k));
    q0.push_back(mk(2, 5'd0, 32'h0000_F000, k + 3));
    repeat (5) @(posedge clk);

    // Requests during FLUSH are ignored
    issue0(1, 0, 0, 0, 0, 1, 0, 32'h80, 32'h0, k);
    q0.push_back(mk(0, 5'd9, 32'h80, k));
    q0.push_back(mk(2, 5'd0, 32'h0000_F000, k + 3));
    @(posedge clk); #1;
    mv = 1; bp = 1; ov = 1;
    #1;
    cmp("mid_flush", {31'b0, flush0}, 32'h1);
    cmp("mid_stall", {31'b0, stall0}, 32'h1);
    cmp("mid_no_exc", {31'b0, exc0}, 32'h0);
    @(posedge clk); #1;
    mv = 0; bp = 0; ov = 0;
    repeat (4) @(posedge clk);

    // Syscall without mem_valid_i is ignored
    issue0(0, 0, 0, 0, 1, 0, 0, 32'h90, 32'h0, k);
    repeat (4) @(posedge clk);

    // Reset in FLUSH drops the redirect
    issue0(1, 0, 1, 0, 0, 0, 0, 32'h300, 32'h0, k);
    q0.push_back(mk(0, 5'd12, 32'h300, k));
    @(posedge clk); #1;
    rst = 1;
    #1;
    cmp("rstmid_flush", {31'b0, flush0}, 32'h0);
    cmp("rstmid_stall", {31'b0, stall0}, 32'h0);
    cmp("rstmid_exception", {31'b0, exc0}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    repeat (3) @(posedge clk);
    cmp("rstmid_no_redirect_yet", {31'b0, redir0}, 32'h0);
    issue0(1, 0, 0, 1, 0, 0, 0, 32'h500, 32'h0, k);
    q0.push_back(mk(0, 5'd10, 32'h500, k));
    q0.push_back(mk(2, 5'd0, 32'h0000_F000, k + 3));
    repeat (5) @(posedge clk);

    // FLUSH_CYCLES=1 instance, syscall held high: one sequence per 4 cycles
    @(posedge clk); #1;
    mv1 = 1; sys1 = 1; pc = 32'h700;
    k = ecnt + 1;
    q1.push_back(mk(0, 5'd8, 32'h700, k));
    q1.push_back(mk(2, 5'd0, 32'h0000_F000, k + 2));
    q1.push_back(mk(0, 5'd8, 32'h700, k + 4));
    q1.push_back(mk(2, 5'd0, 32'h0000_F000, k + 6));
    repeat (8) @(posedge clk);
    #1;
    mv1 = 0; sys1 = 0;
    repeat (6) @(posedge clk);

    cmp("q0_drained", q0.size(), 32'h0);
    cmp("q1_drained", q1.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
